// File: rtl/softmax_pkg.sv
// Shared constants, FSM encoding and helpers for the softmax row-max buffer.
package softmax_pkg;

  localparam int BW_DEF        = 8;
  localparam int VEC_SIZE_DEF  = 5;
  localparam int MAX_BEATS_DEF = 8;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } row_state_e;

  // Most-negative two's-complement value of a w-bit field, sign-extended to 32 bits.
  function automatic logic signed [31:0] most_neg(input int w);
    return -(32'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/softmax_row_max_buffer_vec_max_reduce.sv
// Combinational signed max over one beat, built as a balanced binary tree
// padded up to the next power of two with the most-negative value.
module vec_max_reduce
  import softmax_pkg::*;
#(
  parameter int BW       = BW_DEF,
  parameter int VEC_SIZE = VEC_SIZE_DEF
) (
  input  logic [BW-1:0]        vec [VEC_SIZE],
  output logic signed [BW-1:0] max_o
);

  localparam int P = 1 << $clog2(VEC_SIZE);
  localparam logic signed [BW-1:0] PAD = BW'(most_neg(BW));

  always_comb begin
    // Heap layout: leaves at [P, 2P), each parent i reduces children 2i and 2i+1.
    logic signed [BW-1:0] node [2*P];
    for (int i = 0; i < 2 * P; i++) node[i] = PAD;
    for (int i = 0; i < VEC_SIZE; i++) node[P + i] = $signed(vec[i]);
    for (int i = P - 1; i >= 1; i--) begin
      node[i] = (node[2*i] > node[2*i+1]) ? node[2*i] : node[2*i+1];
    end
    max_o = node[1];
  end

endmodule

// File: rtl/softmax_row_max_buffer.sv
// Row buffer with signed running max: fill a row of beats, then replay them
// with the final row maximum. Optional sticky overflow flag: SOFTMAX_ROW_OVF_EN.
module softmax_row_max_buffer
  import softmax_pkg::*;
#(
  parameter int BW        = BW_DEF,
  parameter int VEC_SIZE  = VEC_SIZE_DEF,
  parameter int MAX_BEATS = MAX_BEATS_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_vec [VEC_SIZE],
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_vec [VEC_SIZE],
  output logic [BW-1:0] out_max,
  output logic          out_last,
  output logic          err_ovf
);

  localparam int AW = $clog2(MAX_BEATS);
  localparam int CW = AW + 1;
  localparam logic signed [BW-1:0] RUN_MAX_INIT = BW'(most_neg(BW));

  row_state_e           state_q, state_d;
  logic [CW-1:0]        wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]        rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]        row_len_q, row_len_d;
  logic signed [BW-1:0] run_max_q, run_max_d;
  logic [BW-1:0]        buf_q [MAX_BEATS][VEC_SIZE];

  logic signed [BW-1:0] beat_max;
  logic                 in_fire;
  logic                 out_fire;
  logic                 forced_end;
  logic                 terminate;

  vec_max_reduce #(
    .BW       (BW),
    .VEC_SIZE (VEC_SIZE)
  ) u_in_max (
    .vec   (in_vec),
    .max_o (beat_max)
  );

  assign in_ready   = (state_q == FILL);
  assign out_valid  = (state_q == DRAIN);
  assign out_last   = out_valid && (rd_cnt_q == row_len_q - CW'(1));
  assign out_max    = run_max_q;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign forced_end = (wr_cnt_q == CW'(MAX_BEATS - 1));
  assign terminate  = in_fire && (in_last || forced_end);

  always_comb begin
    for (int i = 0; i < VEC_SIZE; i++) out_vec[i] = buf_q[rd_cnt_q[AW-1:0]][i];
  end

  // NOTE: every _d gets its hold value first so no path through this block
  // leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    row_len_d = row_len_q;
    run_max_d = run_max_q;

    unique case (state_q)
      FILL: begin
        if (in_fire) begin
          if (beat_max > run_max_q) run_max_d = beat_max;
          wr_cnt_d = wr_cnt_q + CW'(1);
          if (terminate) begin
            row_len_d = wr_cnt_q + CW'(1);
            wr_cnt_d  = '0;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (out_last) begin
            rd_cnt_d  = '0;
            run_max_d = RUN_MAX_INIT;
            state_d   = FILL;
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      row_len_q <= '0;
      run_max_q <= RUN_MAX_INIT;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      row_len_q <= row_len_d;
      run_max_q <= run_max_d;
    end
  end

  // NOTE: the beat store is deliberately not reset; it is only read after
  // being written in the same row, and a reset would cost a wide reset tree.
  always_ff @(posedge clk) begin
    if (in_fire) buf_q[wr_cnt_q[AW-1:0]] <= in_vec;
  end

`ifdef SOFTMAX_ROW_OVF_EN
  logic err_ovf_q, err_ovf_d;

  // Sticky: a row truncated by buffer depth rather than by in_last.
  always_comb begin
    err_ovf_d = err_ovf_q;
    if (terminate && !in_last) err_ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_ovf_q <= 1'b0;
    else        err_ovf_q <= err_ovf_d;
  end

  assign err_ovf = err_ovf_q;
`else
  assign err_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_softmax_row_max_buffer.sv
// Randomized self-checking bench: a queue-based row model predicts every
// replayed beat, its row maximum, out_last and the overflow flag.
module tb_softmax_row_max_buffer;

  localparam int BW  = 8;
  localparam int VS  = 5;
  localparam int MB  = 8;
  localparam int PW  = BW * VS;

  typedef logic [PW-1:0] beat_t;
  typedef struct {
    beat_t         vec;
    logic [BW-1:0] mx;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_vec [VS];
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_vec [VS];
  logic [BW-1:0] out_max;
  logic          out_last;
  logic          err_ovf;

  int n_cmp = 0;
  int n_err = 0;

  exp_t  exp_q [$];
  beat_t pend_q [$];
  logic  ovf_exp = 1'b0;

  softmax_row_max_buffer #(.BW(BW), .VEC_SIZE(VS), .MAX_BEATS(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_max   (out_max),
    .out_last  (out_last),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input int a, input int b, input int c, input int d, input int e);
    beat_t v;
    v[0*BW +: BW] = BW'(a);
    v[1*BW +: BW] = BW'(b);
    v[2*BW +: BW] = BW'(c);
    v[3*BW +: BW] = BW'(d);
    v[4*BW +: BW] = BW'(e);
    return v;
  endfunction

  function automatic beat_t pack_out();
    beat_t v;
    for (int i = 0; i < VS; i++) v[i*BW +: BW] = out_vec[i];
    return v;
  endfunction

  task automatic drive_vec(input beat_t v);
    for (int i = 0; i < VS; i++) in_vec[i] = v[i*BW +: BW];
  endtask

  // Reference: a row ends on in_last or when it reaches MB beats; its maximum
  // is the plain signed maximum of all its elements.
  task automatic model_accept(input beat_t v, input logic last);
    int m;
    pend_q.push_back(v);
    if (last || pend_q.size() == MB) begin
      m = -(1 << (BW - 1));
      foreach (pend_q[k])
        for (int i = 0; i < VS; i++)
          if ($signed(pend_q[k][i*BW +: BW]) > m) m = $signed(pend_q[k][i*BW +: BW]);
`ifdef SOFTMAX_ROW_OVF_EN
      if (!last) ovf_exp = 1'b1;
`endif
      foreach (pend_q[k]) begin
        exp_t e;
        e.vec  = pend_q[k];
        e.mx   = BW'(m);
        e.last = (k == pend_q.size() - 1);
        exp_q.push_back(e);
      end
      pend_q.delete();
    end
  endtask

  // mode 0: random out_ready; 1: always ready; 2: stall 4 cycles after the first beat.
  task automatic drain(input int mode);
    int    cyc = 0;
    logic  held = 1'b0;
    beat_t pv;
    logic [BW-1:0] pm;
    logic  pl;
    while (exp_q.size() > 0) begin
      case (mode)
        1:       out_ready = 1'b1;
        2:       out_ready = !(cyc >= 1 && cyc <= 4);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      drive_vec(beat_t'({$urandom, $urandom}));
      #1;
      if (cyc == 0) check("latency_valid", 64'(out_valid), 64'd1);
      check("drain_in_ready", 64'(in_ready), 64'd0);
      if (held) begin
        check("hold_vec", 64'(pack_out()), 64'(pv));
        check("hold_max", 64'(out_max), 64'(pm));
        check("hold_last", 64'(out_last), 64'(pl));
      end
      if (out_valid && out_ready) begin
        check("out_vec", 64'(pack_out()), 64'(exp_q[0].vec));
        check("out_max", 64'(out_max), 64'(exp_q[0].mx));
        check("out_last", 64'(out_last), 64'(exp_q[0].last));
        void'(exp_q.pop_front());
      end
      held = out_valid && !out_ready;
      pv = pack_out();
      pm = out_max;
      pl = out_last;
      cyc++;
      if (cyc > 300) begin
        check("drain_timeout", 64'd0, 64'd1);
        exp_q.delete();
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1;
    check("refill_in_ready", 64'(in_ready), 64'd1);
    check("refill_out_valid", 64'(out_valid), 64'd0);
    check("err_ovf", 64'(err_ovf), 64'(ovf_exp));
  endtask

  // Present one beat at a negedge; it is taken at the following posedge.
  task automatic feed(input beat_t v, input logic last, input int mode, input bit auto_drain);
    in_valid = 1'b1;
    in_last  = last;
    drive_vec(v);
    #1;
    check("fill_in_ready", 64'(in_ready), 64'd1);
    check("fill_out_valid", 64'(out_valid), 64'd0);
    if (in_ready) model_accept(v, last);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (auto_drain && exp_q.size() > 0) drain(mode);
  endtask

  function automatic beat_t rand_beat();
    beat_t v;
    int    mode = $urandom_range(0, 3);
    for (int i = 0; i < VS; i++) begin
      if (mode == 0)      v[i*BW +: BW] = BW'($urandom_range(0, 3) - 2);
      else if (mode == 1) v[i*BW +: BW] = BW'(8'h80 + $urandom_range(0, 2));
      else                v[i*BW +: BW] = BW'($urandom);
    end
    return v;
  endfunction

  initial begin
    drive_vec('0);
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_max", 64'(out_max), 64'h80);
    check("rst_err_ovf", 64'(err_ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Single-beat row.
    feed(mk(3, -2, 7, 0, 1), 1'b1, 1, 1'b1);

    // Three-beat row, beat maxima 4, 20, -5.
    feed(mk(4, 1, 0, -3, 2), 1'b0, 1, 1'b1);
    feed(mk(-7, 20, 20, 5, 0), 1'b0, 1, 1'b1);
    feed(mk(-5, -9, -128, -6, -5), 1'b1, 1, 1'b1);

    // All-minimum row followed by a row whose max is 1.
    feed(mk(-128, -128, -128, -128, -128), 1'b0, 1, 1'b1);
    feed(mk(-128, -128, -128, -128, -128), 1'b1, 1, 1'b1);
    feed(mk(1, 0, -1, 1, -4), 1'b1, 1, 1'b1);

    // Back-pressure mid-drain with in_valid toggling.
    feed(mk(9, 8, 7, 6, 5), 1'b0, 2, 1'b1);
    feed(mk(-1, -2, 30, -4, -5), 1'b0, 2, 1'b1);
    feed(mk(11, 12, 13, 14, 15), 1'b1, 2, 1'b1);

    // Overflow: eight beats without in_last, then the late in_last beat.
    for (int k = 0; k < MB; k++) feed(mk(k, -k, 2 * k, 0, -50), 1'b0, 1, 1'b1);
    feed(mk(100, 1, 2, 3, 4), 1'b1, 1, 1'b1);

    // Asynchronous reset in the middle of a drain.
    feed(mk(5, 5, 5, 5, 5), 1'b0, 1, 1'b0);
    feed(mk(6, 6, 6, 6, 6), 1'b0, 1, 1'b0);
    feed(mk(7, 7, 7, 7, 70), 1'b1, 1, 1'b0);
    out_ready = 1'b1;
    #1;
    check("pre_rst_out_max", 64'(out_max), 64'd70);
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_out_max", 64'(out_max), 64'h80);
    check("async_rst_err_ovf", 64'(err_ovf), 64'd0);
    exp_q.delete();
    pend_q.delete();
    ovf_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    feed(mk(-3, -9, -1, -7, -2), 1'b0, 0, 1'b1);
    feed(mk(-4, -6, -8, -5, -100), 1'b1, 0, 1'b1);

    // Random rows, some longer than the buffer.
    for (int r = 0; r < 30; r++) begin
      int len = $urandom_range(1, MB + 3);
      for (int k = 0; k < len; k++) feed(rand_beat(), 1'(k == len - 1), 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
